alu_share_arb: RTL

Round-robin arbiter and sequencer that shares one 16-bit flagged adder (existing ALU module) among NREQ requesters. Each requester holds a request with its operand pair. The block grants one requester, registers its operands and runs the add. It then returns a registered sum, the five flags and a one-cycle ack to that requester. It sits between several datapath clients and the single ALU instance.

---
 rtl/alu_share_arb_pkg.sv | 19 +
 rtl/alu_share_arb_if.sv | 31 +++
 rtl/alu_share_arb_alu.sv | 20 ++
 rtl/alu_share_arb_rr_pick.sv | 28 ++
 rtl/alu_share_arb.sv | 100 ++++++++++
 5 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the ALU-sharing round-robin arbiter.
package alu_share_arb_pkg;

   localparam int unsigned DataW = 16;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   typedef struct packed {
      logic [DataW-1:0] sum;
      logic             sign;
      logic             zero;
      logic             carry;
      logic             parity;
      logic             overflow;
   } alu_res_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester-side bus of the shared ALU arbiter: packed requests/operands in, result and ack out.
interface alu_share_arb_if
   import alu_share_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);
   logic [NREQ-1:0]       req;
   logic [NREQ*DataW-1:0] x_in;
   logic [NREQ*DataW-1:0] y_in;
   logic [NREQ-1:0]       ack;
   logic                  busy;
   logic                  done;
   logic [IDW-1:0]        done_id;
   logic [DataW-1:0]      sum;
   logic                  sign;
   logic                  zero;
   logic                  carry;
   logic                  parity;
   logic                  overflow;

   modport master (
      output req, x_in, y_in,
      input  ack, busy, done, done_id, sum, sign, zero, carry, parity, overflow
   );

   modport slave (
      input  req, x_in, y_in,
      output ack, busy, done, done_id, sum, sign, zero, carry, parity, overflow
   );
endinterface

// File: rtl/alu_share_arb_alu.sv
// 16-bit flagged adder shared by all requesters; purely combinational.
module alu_share_arb_alu
   import alu_share_arb_pkg::*;
(
   input  logic [DataW-1:0] a_i,
   input  logic [DataW-1:0] b_i,
   output alu_res_t         res_o
);
   logic [DataW:0] full;

   always_comb begin
      full           = {1'b0, a_i} + {1'b0, b_i};
      res_o.sum      = full[DataW-1:0];
      res_o.carry    = full[DataW];
      res_o.sign     = full[DataW-1];
      res_o.zero     = (full[DataW-1:0] == '0);
      res_o.parity   = ~^full[DataW-1:0];
      res_o.overflow = (a_i[DataW-1] == b_i[DataW-1]) && (full[DataW-1] != a_i[DataW-1]);
   end
endmodule

// File: rtl/alu_share_arb_rr_pick.sv
// Round-robin picker: lowest requesting index at or above rr_ptr_i, wrapping to 0.
module alu_share_arb_rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  rr_ptr_i,
   output logic [IDW-1:0]  gnt_id_o,
   output logic            any_req_o
);
   logic        found;
   int unsigned idx;

   always_comb begin
      gnt_id_o = '0;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr_i) + k) % NREQ;
         if (!found && req_i[idx]) begin
            found    = 1'b1;
            gnt_id_o = IDW'(idx);
         end
      end
   end

   assign any_req_o = |req_i;
endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates NREQ requesters onto one shared adder: IDLE grants, EXEC registers the result,
// DONE pulses ack/done to the served requester.
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input logic             clk,
   input logic             rst_n,
   alu_share_arb_if.slave  bus
);
   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic [IDW-1:0]   done_id_q, done_id_d;
   logic [DataW-1:0] op_x_q, op_x_d;
   logic [DataW-1:0] op_y_q, op_y_d;
   alu_res_t         res_q, res_d;

   logic [IDW-1:0]   pick_id;
   logic             any_req;
   alu_res_t         alu_res;

   alu_share_arb_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_i     (bus.req),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_id_o  (pick_id),
      .any_req_o (any_req)
   );

   alu_share_arb_alu u_alu (
      .a_i   (op_x_q),
      .b_i   (op_y_q),
      .res_o (alu_res)
   );

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_id_d  = gnt_id_q;
      done_id_d = done_id_q;
      op_x_d    = op_x_q;
      op_y_d    = op_y_q;
      res_d     = res_q;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               op_x_d   = bus.x_in[pick_id*DataW +: DataW];
               op_y_d   = bus.y_in[pick_id*DataW +: DataW];
               gnt_id_d = pick_id;
               rr_ptr_d = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + IDW'(1);
               state_d  = StExec;
            end
         end
         StExec: begin
            res_d     = alu_res;
            done_id_d = gnt_id_q;
            state_d   = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         rr_ptr_q  <= '0;
         gnt_id_q  <= '0;
         done_id_q <= '0;
         op_x_q    <= '0;
         op_y_q    <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_id_q  <= gnt_id_d;
         done_id_q <= done_id_d;
         op_x_q    <= op_x_d;
         op_y_q    <= op_y_d;
         res_q     <= res_d;
      end
   end

   // ack/done decode straight from state, so a reset mid-operation suppresses them.
   assign bus.ack      = (state_q == StDone) ? (NREQ'(1) << gnt_id_q) : '0;
   assign bus.done     = (state_q == StDone);
   assign bus.busy     = (state_q == StExec) || (state_q == StDone);
   assign bus.done_id  = done_id_q;
   assign bus.sum      = res_q.sum;
   assign bus.sign     = res_q.sign;
   assign bus.zero     = res_q.zero;
   assign bus.carry    = res_q.carry;
   assign bus.parity   = res_q.parity;
   assign bus.overflow = res_q.overflow;
endmodule
